mealy_fsm_engine: RTL and testbench
===================================

Name: mealy_fsm_engine

Overview:
Table-driven, parametrised Mealy state machine. Replaces hand-coded per-diagram FSMs with a single engine whose transition/output table is loaded at run time through a config write port. Supports multi-bit input and output symbols and a programmable initial state. Flags and counts unmatched transitions instead of silently holding.

Parameters:
N_STATES, 8, number of legal states; must be at least 2.
STATE_W, 3, state encoding width; must satisfy 2^STATE_W >= N_STATES.
IN_W, 1, input symbol width.
OUT_W, 1, output symbol width.
INIT_STATE, 0, state entered on reset and on soft_init; must be less than N_STATES.
CNT_W, 8, miss counter width.
TBL_D, N_STATES*2^IN_W, table depth (derived; do not override).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
en  in  1  step enable; one transition evaluated per cycle while high
in_sym  in  IN_W  input symbol
soft_init  in  1  synchronous return to INIT_STATE; table is kept
cfg_we  in  1  table write strobe
cfg_addr  in  STATE_W+IN_W  table index {state, in_sym}
cfg_next  in  STATE_W  next-state field
cfg_out  in  OUT_W  output field
cfg_valid  in  1  entry-valid field
state_q  out  STATE_W  current state
out_sym  out  OUT_W  registered output symbol
hit  out  1  one-cycle pulse: last step took a valid transition
miss  out  1  one-cycle pulse: last step found no usable entry
miss_cnt  out  CNT_W  saturating count of misses

Behaviour:
- Reset (async, rst=1): state_q=INIT_STATE, out_sym=0, hit=0, miss=0, miss_cnt=0, all table valid bits cleared. Entry fields need not be cleared.
- Table: TBL_D entries of {valid, next, out}, indexed {state_q, in_sym}.
  - Write on posedge when cfg_we=1.
  - Addresses with state part >= N_STATES are ignored.
- Step: on posedge, when en=1 and soft_init=0, read entry E at {state_q, in_sym}.
  - Usable means E.valid=1 and E.next < N_STATES.
  - Usable: state_q<=E.next, out_sym<=E.out, hit<=1, miss<=0.
  - Not usable: state_q and out_sym hold, miss<=1, hit<=0, miss_cnt increments and saturates at all-ones without wrapping.
- Latency: one cycle. State, output and flags are visible the cycle after the sampling edge.
- en=0: no step; state_q, out_sym and miss_cnt hold; hit=0, miss=0.
- soft_init=1 (priority over en): state_q<=INIT_STATE, out_sym<=0, hit=0, miss=0. miss_cnt and table are unchanged.
- Write/read collision: when cfg_we writes the address being stepped in the same cycle, the step uses the old contents. The new entry takes effect from the next cycle.
- cfg_we is independent of en and soft_init. Writes are allowed in every cycle, including while stepping.
- Determinism: one entry per {state, symbol}, so overlapping or conflicting rules cannot exist. The last write to an address wins.
- Self-loops (E.next == state_q) are legal and count as hits.
- rst asserted mid-step: all registers and valid bits return to reset values immediately, regardless of clk.
- hit and miss are never high together.

Test Plan:
- Reset, then en=1, in_sym=1 with an empty table -> state_q=0, out_sym=0, miss=1 every cycle; after 300 cycles miss_cnt=255 and holds.
- Program {0,1}->{next=1,out=1}, {1,0}->{next=1,out=1}, {1,1}->{next=2,out=0}; drive in_sym 1,0,0,1 -> state_q sequence 1,1,1,2, out_sym 1,1,1,0, hit=1 each cycle.
- Program {2,0}->{next=7,valid=1} with N_STATES=5 -> in state 2 with in_sym=0: miss=1, state_q stays 2, miss_cnt+1.
- Collision: in state 0, in_sym=1, entry {0,1}->{next=3}; same-cycle write {0,1}->{next=4} -> state_q=3 this step. Return to 0 and repeat the input -> state_q=4.
- soft_init and en both high while in state 3 with out_sym=1 -> next cycle state_q=0, out_sym=0, hit=0, miss=0, miss_cnt unchanged. Previously programmed entries still produce hits.
- Assert rst asynchronously between edges while in state 2 -> state_q=0 at once, miss_cnt=0. The next step on any symbol gives miss=1 because the table is invalidated.

Source files
------------

// File: rtl/mealy_fsm_engine.sv
// Table-driven Mealy state machine.
// The transition/output table is loaded at run time through a config write port.
module mealy_fsm_engine #(
  parameter int N_STATES   = 8,
  parameter int STATE_W    = 3,
  parameter int IN_W       = 1,
  parameter int OUT_W      = 1,
  parameter int INIT_STATE = 0,
  parameter int CNT_W      = 8,
  parameter int TBL_D      = N_STATES * (2 ** IN_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [IN_W-1:0]         in_sym,
  input  logic                    soft_init,
  input  logic                    cfg_we,
  input  logic [STATE_W+IN_W-1:0] cfg_addr,
  input  logic [STATE_W-1:0]      cfg_next,
  input  logic [OUT_W-1:0]        cfg_out,
  input  logic                    cfg_valid,
  output logic [STATE_W-1:0]      state_q,
  output logic [OUT_W-1:0]        out_sym,
  output logic                    hit,
  output logic                    miss,
  output logic [CNT_W-1:0]        miss_cnt
);

  localparam int AW    = STATE_W + IN_W;
  localparam int IDX_W = (TBL_D > 1) ? $clog2(TBL_D) : 1;

  localparam logic [STATE_W:0]   NS_L   = (STATE_W + 1)'(N_STATES);
  localparam logic [STATE_W-1:0] INIT_L = STATE_W'(INIT_STATE);

  logic [TBL_D-1:0]   vld_q;
  logic [STATE_W-1:0] nxt_q [TBL_D];
  logic [OUT_W-1:0]   out_q [TBL_D];

  logic [STATE_W-1:0] wr_st;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               wr_ok;
  logic [STATE_W-1:0] e_next;
  logic [OUT_W-1:0]   e_out;
  logic               usable;
  logic [CNT_W-1:0]   cnt_d;

  // {state, sym} is state*2^IN_W + sym, so legal addresses
  // index the table directly once out-of-range states are dropped.
  assign wr_st  = cfg_addr[AW-1:IN_W];
  assign wr_ok  = cfg_we && ({1'b0, wr_st} < NS_L);
  assign wr_idx = IDX_W'(cfg_addr);
  assign rd_idx = IDX_W'({state_q, in_sym});

  assign e_next = nxt_q[rd_idx];
  assign e_out  = out_q[rd_idx];
  assign usable = vld_q[rd_idx] && ({1'b0, e_next} < NS_L);

  always_comb begin
    cnt_d = miss_cnt;
    if (miss_cnt != '1)
      cnt_d = miss_cnt + CNT_W'(1);
  end

  // Entry payload is qualified by its valid bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      nxt_q[wr_idx] <= cfg_next;
      out_q[wr_idx] <= cfg_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      vld_q <= '0;
    else if (wr_ok)
      vld_q[wr_idx] <= cfg_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT_L;
      out_sym  <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
      miss_cnt <= '0;
    end else if (soft_init) begin
      state_q <= INIT_L;
      out_sym <= '0;
      hit     <= 1'b0;
      miss    <= 1'b0;
    end else if (en) begin
      if (usable) begin
        state_q <= e_next;
        out_sym <= e_out;
        hit     <= 1'b1;
        miss    <= 1'b0;
      end else begin
        hit      <= 1'b0;
        miss     <= 1'b1;
        miss_cnt <= cnt_d;
      end
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mealy_fsm_engine.sv
// Bench for mealy_fsm_engine: directed scenarios plus random
// stimulus against a table-lookup reference model.
module tb_mealy_fsm_engine;

  localparam int NS = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] in_sym;
  logic       soft_init;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [2:0] cfg_next;
  logic [1:0] cfg_out;
  logic       cfg_valid;
  logic [2:0] state_q;
  logic [1:0] out_sym;
  logic       hit;
  logic       miss;
  logic [7:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays indexed by [state][symbol]
  bit m_v [NS][4];
  int m_n [NS][4];
  int m_o [NS][4];
  int ms, mo, mcnt;
  bit mh, mm;

  mealy_fsm_engine #(
    .N_STATES(NS), .STATE_W(3), .IN_W(2), .OUT_W(2),
    .INIT_STATE(0), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_sym(in_sym),
    .soft_init(soft_init), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_next(cfg_next), .cfg_out(cfg_out), .cfg_valid(cfg_valid),
    .state_q(state_q), .out_sym(out_sym), .hit(hit), .miss(miss),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int s = 0; s < NS; s++)
      for (int y = 0; y < 4; y++) m_v[s][y] = 1'b0;
    ms = 0; mo = 0; mcnt = 0; mh = 1'b0; mm = 1'b0;
  endfunction

  function automatic void model_tick();
    int ws, wy, y;
    y  = int'(in_sym);
    ws = int'(cfg_addr) / 4;
    wy = int'(cfg_addr) % 4;
    if (soft_init) begin
      ms = 0; mo = 0; mh = 1'b0; mm = 1'b0;
    end else if (en) begin
      if (m_v[ms][y] && m_n[ms][y] < NS) begin
        mo = m_o[ms][y]; ms = m_n[ms][y]; mh = 1'b1; mm = 1'b0;
      end else begin
        mh = 1'b0; mm = 1'b1;
        if (mcnt < 255) mcnt++;
      end
    end else begin
      mh = 1'b0; mm = 1'b0;
    end
    if (cfg_we && ws < NS) begin
      m_v[ws][wy] = cfg_valid;
      m_n[ws][wy] = int'(cfg_next);
      m_o[ws][wy] = int'(cfg_out);
    end
  endfunction

  task automatic cycle();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int y, input int n,
                    input int o, input bit v);
    en = 1'b0; soft_init = 1'b0;
    cfg_we = 1'b1;
    cfg_addr = {3'(s), 2'(y)};
    cfg_next = 3'(n); cfg_out = 2'(o); cfg_valid = v;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; model_reset();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_sym = '0; soft_init = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_next = '0;
    cfg_out = '0; cfg_valid = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({state_q, out_sym, hit, miss, miss_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0",
               {state_q, out_sym, hit, miss, miss_cnt});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    en = 1'b1; in_sym = 2'd1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      checks++;
      if (!(miss === 1'b1 && hit === 1'b0 && state_q === 3'd0
            && out_sym === 2'd0)) begin
        errors++;
        $display("FAIL empty_miss cyc %0d got st=%0d miss=%b hit=%b want st=0 miss=1 hit=0",
                 i, state_q, miss, hit);
      end
    end
    checks++;
    if (miss_cnt !== 8'd255) begin
      errors++;
      $display("FAIL miss_sat got %0d want 255", miss_cnt);
    end
    cycle();
    checks++;
    if (miss_cnt !== 8'd255) begin
      errors++;
      $display("FAIL miss_hold got %0d want 255", miss_cnt);
    end
    en = 1'b0;
  endtask

  task automatic test_program_seq();
    int syms [4] = '{1, 0, 0, 1};
    int exp_s [4] = '{1, 1, 1, 2};
    int exp_o [4] = '{1, 1, 1, 0};
    wr(0, 1, 1, 1, 1'b1);
    wr(1, 0, 1, 1, 1'b1);
    wr(1, 1, 2, 0, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sym = 2'(syms[i]);
      cycle();
      checks++;
      if (!(state_q === 3'(exp_s[i]) && out_sym === 2'(exp_o[i])
            && hit === 1'b1 && miss === 1'b0)) begin
        errors++;
        $display("FAIL seq step %0d got st=%0d out=%0d hit=%b want st=%0d out=%0d hit=1",
                 i, state_q, out_sym, hit, exp_s[i], exp_o[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_bad_next();
    wr(2, 0, 7, 3, 1'b1);
    en = 1'b1; in_sym = 2'd0;
    cycle();
    checks++;
    if (!(miss === 1'b1 && hit === 1'b0 && state_q === 3'd2
          && out_sym === 2'd0 && miss_cnt === 8'd1)) begin
      errors++;
      $display("FAIL bad_next got st=%0d miss=%b cnt=%0d want st=2 miss=1 cnt=1",
               state_q, miss, miss_cnt);
    end
    en = 1'b0;
  endtask

  task automatic test_collision();
    soft_init = 1'b1;
    cycle();
    soft_init = 1'b0;
    wr(0, 1, 3, 2, 1'b1);
    en = 1'b1; in_sym = 2'd1;
    cfg_we = 1'b1; cfg_addr = {3'd0, 2'd1};
    cfg_next = 3'd4; cfg_out = 2'd1; cfg_valid = 1'b1;
    cycle();
    cfg_we = 1'b0;
    checks++;
    if (!(state_q === 3'd3 && out_sym === 2'd2 && hit === 1'b1)) begin
      errors++;
      $display("FAIL collision_old got st=%0d out=%0d want st=3 out=2",
               state_q, out_sym);
    end
    en = 1'b0; soft_init = 1'b1;
    cycle();
    soft_init = 1'b0; en = 1'b1;
    cycle();
    checks++;
    if (!(state_q === 3'd4 && out_sym === 2'd1 && hit === 1'b1)) begin
      errors++;
      $display("FAIL collision_new got st=%0d out=%0d want st=4 out=1",
               state_q, out_sym);
    end
    en = 1'b0;
  endtask

  task automatic test_soft_init();
    logic [7:0] cnt0;
    wr(0, 2, 3, 1, 1'b1);
    soft_init = 1'b1;
    cycle();
    soft_init = 1'b0; en = 1'b1; in_sym = 2'd2;
    cycle();
    cnt0 = 8'(mcnt);
    checks++;
    if (!(state_q === 3'd3 && out_sym === 2'd1)) begin
      errors++;
      $display("FAIL soft_pre got st=%0d out=%0d want st=3 out=1",
               state_q, out_sym);
    end
    soft_init = 1'b1;
    cycle();
    checks++;
    if (!(state_q === 3'd0 && out_sym === 2'd0 && hit === 1'b0
          && miss === 1'b0 && miss_cnt === cnt0)) begin
      errors++;
      $display("FAIL soft_init got st=%0d out=%0d h=%b m=%b cnt=%0d want 0 0 0 0 %0d",
               state_q, out_sym, hit, miss, miss_cnt, cnt0);
    end
    soft_init = 1'b0;
    cycle();
    checks++;
    if (!(state_q === 3'd3 && hit === 1'b1)) begin
      errors++;
      $display("FAIL soft_keep got st=%0d hit=%b want st=3 hit=1",
               state_q, hit);
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      soft_init = ($urandom_range(0, 15) == 0);
      in_sym    = 2'($urandom);
      cfg_we    = ($urandom_range(0, 2) == 0);
      cfg_addr  = 5'($urandom);
      cfg_next  = 3'($urandom_range(0, 6));
      cfg_out   = 2'($urandom);
      cfg_valid = ($urandom_range(0, 4) != 0);
      cycle();
      checks++;
      if ({state_q, out_sym, hit, miss, miss_cnt} !==
          {3'(ms), 2'(mo), mh, mm, 8'(mcnt)}) begin
        errors++;
        $display("FAIL random cyc %0d got st=%0d o=%0d h=%b m=%b c=%0d want st=%0d o=%0d h=%b m=%b c=%0d",
                 i, state_q, out_sym, hit, miss, miss_cnt,
                 ms, mo, mh, mm, mcnt);
      end
      checks++;
      if (hit === 1'b1 && miss === 1'b1) begin
        errors++;
        $display("FAIL hit_miss_excl cyc %0d got both high want exclusive", i);
      end
    end
    cfg_we = 1'b0; en = 1'b0; soft_init = 1'b0;
  endtask

  task automatic test_async_reset();
    wr(0, 3, 2, 1, 1'b1);
    soft_init = 1'b1;
    cycle();
    soft_init = 1'b0; en = 1'b1; in_sym = 2'd3;
    cycle();
    en = 1'b0;
    checks++;
    if (!(state_q === 3'd2 && miss_cnt !== 8'd0)) begin
      errors++;
      $display("FAIL async_pre got st=%0d cnt=%0d want st=2 cnt>0",
               state_q, miss_cnt);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (!(state_q === 3'd0 && miss_cnt === 8'd0 && out_sym === 2'd0)) begin
      errors++;
      $display("FAIL async_rst got st=%0d cnt=%0d want st=0 cnt=0",
               state_q, miss_cnt);
    end
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    en = 1'b1; in_sym = 2'd3;
    cycle();
    checks++;
    if (!(miss === 1'b1 && hit === 1'b0 && state_q === 3'd0)) begin
      errors++;
      $display("FAIL post_rst_miss got st=%0d miss=%b want st=0 miss=1",
               state_q, miss);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saturate();
    do_reset();
    test_program_seq();
    test_bad_next();
    test_collision();
    test_soft_init();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
